// File: rtl/sar_search_pkg.sv
// -----------------------------------------------------------------------------
// sar_search_pkg
// Shared definitions for the successive-approximation search controller:
//   - FSM state encodings (IDLE=0, SEARCH=1, DONE=2)
//   - bit positions inside the comparator flag vector {greater, equal, less}
//   - helper that checks the flag vector is exactly one-hot
// -----------------------------------------------------------------------------
package sar_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } sar_state_t;

  // Flag vector order is {greater, equal, less}.
  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

  // A consistent comparator raises exactly one of its three flags.
  function automatic logic flags_onehot(input logic [2:0] flags);
    return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  endfunction

endpackage

// File: rtl/sar_search.sv
// -----------------------------------------------------------------------------
// sar_search
// Successive-approximation controller driving the B side of an external
// magnitude comparator. Each SEARCH cycle it reads {greater, equal, less} for
// the current trial and refines one bit, MSB first, until the comparator's A
// operand is known.
//
// Optional feature: define SAR_EARLY_EXIT_EN to stop the search as soon as the
// comparator reports equal. Without it, equal at k>0 keeps the bit (like
// greater), so every search takes exactly WIDTH steps.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request a new search (only looked at in IDLE)
//   greater   in   comparator flag A > trial
//   equal     in   comparator flag A == trial
//   less      in   comparator flag A < trial
//   trial     out  registered value driven to comparator B
//   busy      out  high while searching
//   done      out  one-cycle pulse when a search ends
//   result    out  determined value, held until the next search completes
//   err       out  inconsistent comparator flags seen in the last search
//   state_dbg out  current FSM state (sar_state_t encoding)
//
// Handshake: start is a level sampled on the rising edge while in IDLE; any
// start seen in SEARCH or DONE is dropped, never queued. done is high for the
// single cycle the FSM spends in DONE, and busy is never high in that cycle.
// -----------------------------------------------------------------------------
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             greater,
  input  logic             equal,
  input  logic             less,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0]    K_TOP   = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_trial, w_trial_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_err, w_err_nxt;
  logic [2:0]       w_flags;
  logic             w_last;

  assign w_flags = {greater, equal, less};
  assign w_last  = (r_k == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_trial  <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_trial  <= w_trial_nxt;
      r_k      <= w_k_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_trial_nxt  = r_trial;
    w_k_nxt      = r_k;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SEARCH;
          w_trial_nxt = MSB_ONE;
          w_k_nxt     = K_TOP;
          w_err_nxt   = 1'b0;
        end
      end
      ST_SEARCH: begin
        busy = 1'b1;
        if (!flags_onehot(w_flags)) begin
          w_err_nxt    = 1'b1;
          w_result_nxt = r_trial;
          w_state_nxt  = ST_DONE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (w_flags[FLAG_EQ]) begin
          w_result_nxt = r_trial;
          w_state_nxt  = ST_DONE;
        end
`endif
        else if (w_last) begin
          // Last bit: less means bit0 overshoots; greater cannot happen with
          // a consistent comparator because every lower bit is exhausted.
          if (w_flags[FLAG_LT]) begin
            w_result_nxt = {r_trial[WIDTH-1:1], 1'b0};
          end else if (w_flags[FLAG_EQ]) begin
            w_result_nxt = r_trial;
          end else begin
            w_err_nxt    = 1'b1;
            w_result_nxt = r_trial;
          end
          w_state_nxt = ST_DONE;
        end else begin
          // greater (or equal when not exiting early) keeps bit k.
          w_trial_nxt[r_k]        = ~w_flags[FLAG_LT];
          w_trial_nxt[r_k - 1'b1] = 1'b1;
          w_k_nxt                 = r_k - 1'b1;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign trial     = r_trial;
  assign result    = r_result;
  assign err       = r_err;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_sar_search.sv
// -----------------------------------------------------------------------------
// tb_sar_search
// Directed bench: a behavioural 4-bit comparator closes the loop around
// sar_search; flags can be overridden to inject inconsistent comparisons.
// -----------------------------------------------------------------------------
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       greater;
  logic       equal;
  logic       less;
  logic [3:0] trial;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;
  logic [1:0] state_dbg;

  logic [3:0] a_val;
  logic       frc_en;
  logic [2:0] frc_flags;

  int checks;
  int errors;

  // Behavioural comparator in the loop, with a flag override.
  assign {greater, equal, less} = frc_en ? frc_flags :
                                  {a_val > trial, a_val == trial, a_val < trial};

  sar_search #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .greater   (greater),
    .equal     (equal),
    .less      (less),
    .trial     (trial),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait_timeout", 16'(guard >= 40), 16'd0);
  endtask

  task automatic pulse_start();
    wait_idle();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one search on target a and checks latency, result, err and,
  // optionally, the sequence of trials presented during SEARCH.
  task automatic run_search(input string tag, input logic [3:0] a,
                            input logic [3:0] exp_res, input logic exp_err,
                            input int exp_lat, input logic chk_seq,
                            input logic [15:0] exp_log);
    int cyc;
    int ovl;
    logic [15:0] log_v;
    a_val = a;
    pulse_start();
    cyc   = 0;
    ovl   = 0;
    log_v = '0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy && done) ovl++;
      if (busy) log_v = {log_v[11:0], trial};
      if (done) break;
    end
    chk({tag, "_latency"}, 16'(cyc), 16'(exp_lat));
    chk({tag, "_result"},  {12'd0, result}, {12'd0, exp_res});
    chk({tag, "_err"},     {15'd0, err}, {15'd0, exp_err});
    chk({tag, "_overlap"}, 16'(ovl), 16'd0);
    if (chk_seq) chk({tag, "_trials"}, log_v, exp_log);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dcount;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a_val     = 4'd0;
    frc_en    = 1'b0;
    frc_flags = 3'b000;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_trial",  {12'd0, trial}, 16'h0000);
    chk("rst_busy",   {15'd0, busy},  16'h0000);
    chk("rst_done",   {15'd0, done},  16'h0000);
    chk("rst_result", {12'd0, result},16'h0000);
    chk("rst_err",    {15'd0, err},   16'h0000);
    chk("rst_state",  {14'd0, state_dbg}, 16'h0000);
    rst_n = 1'b1;

    // A=1001: trials 1000,1100,1010,1001, done at cycle 5 in both builds
    run_search("a9", 4'b1001, 4'b1001, 1'b0, 5, 1'b1, 16'h8CA9);

    // A=1000: equal on the first trial
`ifdef SAR_EARLY_EXIT_EN
    run_search("a8", 4'b1000, 4'b1000, 1'b0, 2, 1'b1, 16'h0008);
`else
    run_search("a8", 4'b1000, 4'b1000, 1'b0, 5, 1'b1, 16'h8CA9);
`endif

    // Extremes
    run_search("a0", 4'b0000, 4'b0000, 1'b0, 5, 1'b1, 16'h8421);
    run_search("aF", 4'b1111, 4'b1111, 1'b0, 5, 1'b1, 16'h8CEF);

    // Exhaustive sweep, back-to-back starts
    for (int v = 0; v < 16; v++) begin
`ifdef SAR_EARLY_EXIT_EN
      run_search("sweep", 4'(v), 4'(v), 1'b0, (v == 8) ? 2 : (v == 4 || v == 12) ? 3 :
                 (v == 2 || v == 6 || v == 10 || v == 14) ? 4 : 5, 1'b0, 16'h0000);
`else
      run_search("sweep", 4'(v), 4'(v), 1'b0, 5, 1'b0, 16'h0000);
`endif
    end

    // Inconsistent flags 110 on the second search cycle, A=1100
    a_val = 4'b1100;
    pulse_start();
    @(negedge clk);            // cycle 1, trial 1000
    @(negedge clk);            // cycle 2, trial 1100
    chk("frc_trial", {12'd0, trial}, 16'h000C);
    frc_flags = 3'b110;
    frc_en    = 1'b1;
    @(negedge clk);            // cycle 3
    frc_en    = 1'b0;
    chk("frc_done",   {15'd0, done},   16'h0001);
    chk("frc_err",    {15'd0, err},    16'h0001);
    chk("frc_result", {12'd0, result}, 16'h000C);

    // Reset during step 2 of a search on A=0101
    a_val = 4'b0101;
    pulse_start();
    @(negedge clk);            // cycle 1
    @(negedge clk);            // cycle 2
    rst_n = 1'b0;
    #1;
    chk("mrst_trial",  {12'd0, trial},  16'h0000);
    chk("mrst_busy",   {15'd0, busy},   16'h0000);
    chk("mrst_done",   {15'd0, done},   16'h0000);
    chk("mrst_result", {12'd0, result}, 16'h0000);
    chk("mrst_err",    {15'd0, err},    16'h0000);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mrst_no_done", 16'(dcount), 16'd0);

    // Fresh search after reset: trials 1000,0100,0110,0101
    run_search("a5", 4'b0101, 4'b0101, 1'b0, 5, 1'b1, 16'h8465);

    // Start held during a search is not queued: after done, the FSM stays idle
    a_val = 4'b0011;
    pulse_start();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("noqueue_done_pulses", 16'(dcount), 16'd1);
    chk("noqueue_result", {12'd0, result}, 16'h0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
